// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: load/store funct3 codes and LSU FSM states.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory request/ack bus; master = LSU, slave = memory. Fields hold stable
// while DmemReq is high until the single-cycle DmemAck.
interface lsu_mem_if #(parameter int DMEM_W = 32);

   logic                  DmemReq;
   logic                  DmemWe;
   logic [DMEM_W-1:0]     DmemAddr;
   logic [DMEM_W-1:0]     DmemWData;
   logic [DMEM_W/8-1:0]   DmemBe;
   logic [DMEM_W-1:0]     DmemRData;
   logic                  DmemAck;

   modport master (
      output DmemReq, DmemWe, DmemAddr, DmemWData, DmemBe,
      input  DmemRData, DmemAck
   );

   modport slave (
      input  DmemReq, DmemWe, DmemAddr, DmemWData, DmemBe,
      output DmemRData, DmemAck
   );

endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c   = rdata_i[{off_i, 3'b000} +: 8];
      half_c   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      result_o = rdata_i;
      case (funct3_i)
         F3_B:    result_o = {{24{byte_c[7]}}, byte_c};
         F3_BU:   result_o = {24'h0, byte_c};
         F3_H:    result_o = {{16{half_c[15]}}, half_c};
         F3_HU:   result_o = {16'h0, half_c};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem.sv
// M-stage load/store unit: one bus access per request, stalling the pipe until ack.
// Latency: 1 issue cycle + N>=1 BUSY cycles + 1 DONE cycle; faults skip the bus.
module lsu_mem
   import riscv_pkg::*;
#(
   parameter int DMEM_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              MemReqM,
   input  logic              MemWriteM,
   input  logic [2:0]        Funct3M,
   input  logic [DMEM_W-1:0] ALUResultM,
   input  logic [DMEM_W-1:0] WriteDataM,
   output logic [DMEM_W-1:0] ReadDataM,
   output logic              StallM,
   output logic              FaultM,
   lsu_mem_if.master         dmem
);

   lsu_state_t             state_q;
   logic [DMEM_W-1:0]      rdata_q;
   logic                   fault_q;
   logic                   req_q;
   logic                   we_q;
   logic [DMEM_W-1:0]      addr_q;
   logic [DMEM_W-1:0]      wdata_q;
   logic [DMEM_W/8-1:0]    be_q;
   logic [2:0]             f3_q;
   logic [1:0]             off_q;

   logic                   fault_c;
   logic [DMEM_W/8-1:0]    be_c;
   logic [DMEM_W-1:0]      wdata_c;
   logic [DMEM_W-1:0]      load_c;

   // Unsigned size codes are load-only; any store with Funct3M[2] set is illegal.
   always_comb begin
      fault_c = 1'b0;
      case (Funct3M)
         F3_B, F3_BU: fault_c = MemWriteM & Funct3M[2];
         F3_H, F3_HU: fault_c = ALUResultM[0] | (MemWriteM & Funct3M[2]);
         F3_W:        fault_c = |ALUResultM[1:0];
         default:     fault_c = 1'b1;
      endcase
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = '0;
      if (MemWriteM) begin
         case (Funct3M[1:0])
            2'b00: begin
               be_c    = 4'b0001 << ALUResultM[1:0];
               wdata_c = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_c    = 4'b0011 << ALUResultM[1:0];
               wdata_c = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_c    = 4'b1111;
               wdata_c = WriteDataM;
            end
         endcase
      end
   end

   lsu_load_align u_align (
      .rdata_i  (dmem.DmemRData),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .result_o (load_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
         fault_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         f3_q    <= '0;
         off_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (MemReqM) begin
                  if (fault_c) begin
                     state_q <= DONE;
                     fault_q <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     state_q <= BUSY;
                     req_q   <= 1'b1;
                     we_q    <= MemWriteM;
                     addr_q  <= {ALUResultM[DMEM_W-1:2], 2'b00};
                     wdata_q <= wdata_c;
                     be_q    <= be_c;
                     f3_q    <= Funct3M;
                     off_q   <= ALUResultM[1:0];
                  end
               end
            end
            BUSY: begin
               if (dmem.DmemAck) begin
                  state_q <= DONE;
                  req_q   <= 1'b0;
                  rdata_q <= we_q ? '0 : load_c;
               end
            end
            DONE: begin
               state_q <= IDLE;
               fault_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign StallM         = ~rst & (((state_q == IDLE) & MemReqM) | (state_q == BUSY));
   assign ReadDataM      = rdata_q;
   assign FaultM         = fault_q;
   assign dmem.DmemReq   = req_q;
   assign dmem.DmemWe    = we_q;
   assign dmem.DmemAddr  = addr_q;
   assign dmem.DmemWData = wdata_q;
   assign dmem.DmemBe    = be_q;

endmodule

// File: tb/tb_lsu_mem.sv
module tb_lsu_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemReqM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [2:0]  Funct3M = 3'b010;
   logic [31:0] ALUResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        FaultM;

   lsu_mem_if dmem ();

   lsu_mem dut (
      .clk        (clk),
      .rst        (rst),
      .MemReqM    (MemReqM),
      .MemWriteM  (MemWriteM),
      .Funct3M    (Funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .FaultM     (FaultM),
      .dmem       (dmem)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      int          stall;
   } exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      int          stall;
      int          busy;
      int          req_lat;
      bit          stable;
      bit          done;
      logic        req_in_done;
   } obs_t;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          dly;
      exp_t        e;
   } vec_t;

   exp_t sb[$];

   // Drives one request and plays the memory side; ack comes in BUSY cycle dly+1.
   task automatic drive_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int dly,
                               output obs_t o);
      bit first = 1'b1;
      o = '{rdata: '0, fault: 1'b0, addr: '0, be: '0, wdata: '0, we: 1'b0, stall: 0,
            busy: 0, req_lat: -1, stable: 1'b1, done: 1'b0, req_in_done: 1'b0};
      MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
      for (int cyc = 0; cyc < 64; cyc++) begin
         @(negedge clk);
         dmem.DmemAck   = 1'b0;
         dmem.DmemRData = 32'hA5A5_A5A5;
         if (dmem.DmemReq) begin
            if (first) begin
               o.addr = dmem.DmemAddr; o.be = dmem.DmemBe; o.wdata = dmem.DmemWData;
               o.we = dmem.DmemWe; o.req_lat = cyc; first = 1'b0;
            end else if (o.addr !== dmem.DmemAddr || o.be !== dmem.DmemBe ||
                         o.wdata !== dmem.DmemWData || o.we !== dmem.DmemWe) begin
               o.stable = 1'b0;
            end
            o.busy++;
            if (o.busy == dly + 1) begin
               dmem.DmemAck = 1'b1; dmem.DmemRData = rd;
            end
         end
         if (StallM) o.stall++;
         else if (o.stall > 0) begin
            o.done = 1'b1; o.rdata = ReadDataM; o.fault = FaultM; o.req_in_done = dmem.DmemReq;
            break;
         end
      end
      @(posedge clk); #1;
      MemReqM = 1'b0; dmem.DmemAck = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; MemReqM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", StallM); end
      n_checks++; if (dmem.DmemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", dmem.DmemReq); end
      n_checks++; if (ReadDataM !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", ReadDataM); end
      n_checks++; if (FaultM !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", FaultM); end
      n_checks++;
      if ({dmem.DmemWe, dmem.DmemAddr, dmem.DmemWData, dmem.DmemBe} !== 69'h0) begin
         n_fail++; $display("FAIL reset_bus: got we=%b addr=%h wdata=%h be=%b expected all 0",
                             dmem.DmemWe, dmem.DmemAddr, dmem.DmemWData, dmem.DmemBe);
      end
      @(posedge clk); #1;
      rst = 1'b0; MemReqM = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_stores();
      vec_t v[4];
      obs_t o;
      exp_t e;
      v[0] = '{1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3,
               '{32'h0, 1'b0, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1, 5}};
      v[1] = '{1'b1, 3'b000, 32'h001, 32'h0000_00AB, 32'h0, 0,
               '{32'h0, 1'b0, 32'h000, 4'b0010, 32'hABAB_ABAB, 1'b1, 2}};
      v[2] = '{1'b1, 3'b010, 32'h0FC, 32'hCAFE_BABE, 32'h0, 1,
               '{32'h0, 1'b0, 32'h0FC, 4'b1111, 32'hCAFE_BABE, 1'b1, 3}};
      v[3] = '{1'b1, 3'b000, 32'h003, 32'h1234_5678, 32'h0, 0,
               '{32'h0, 1'b0, 32'h000, 4'b1000, 32'h7878_7878, 1'b1, 2}};
      for (int i = 0; i < 4; i++) begin
         sb.push_back(v[i].e);
         drive_access(v[i].we, v[i].f3, v[i].a, v[i].wd, v[i].rd, v[i].dly, o);
         e = sb.pop_front();
         n_checks++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL store[%0d] done: got %b expected 1 (timeout)", i, o.done); end
         n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL store[%0d] addr: got %h expected %h", i, o.addr, e.addr); end
         n_checks++; if (o.be !== e.be) begin n_fail++; $display("FAIL store[%0d] be: got %b expected %b", i, o.be, e.be); end
         n_checks++; if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL store[%0d] wdata: got %h expected %h", i, o.wdata, e.wdata); end
         n_checks++; if (o.we !== e.we) begin n_fail++; $display("FAIL store[%0d] we: got %b expected %b", i, o.we, e.we); end
         n_checks++; if (o.stall != e.stall) begin n_fail++; $display("FAIL store[%0d] stall: got %0d expected %0d", i, o.stall, e.stall); end
         n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL store[%0d] stable: got %b expected 1", i, o.stable); end
         n_checks++; if (o.req_lat != 1) begin n_fail++; $display("FAIL store[%0d] req_lat: got %0d expected 1", i, o.req_lat); end
         n_checks++; if (o.rdata !== e.rdata || o.fault !== e.fault) begin
            n_fail++; $display("FAIL store[%0d] done_out: got rdata=%h fault=%b expected %h %b", i, o.rdata, o.fault, e.rdata, e.fault);
         end
         n_checks++; if (o.req_in_done !== 1'b0) begin n_fail++; $display("FAIL store[%0d] req_in_done: got %b expected 0", i, o.req_in_done); end
      end
   endtask

   task automatic test_loads();
      vec_t v[7];
      obs_t o;
      exp_t e;
      v[0] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, '{32'hDEAD_BEEF, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 2}};
      v[1] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, '{32'hFFFF_FF80, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 2}};
      v[2] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, '{32'h0000_0080, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 2}};
      v[3] = '{1'b0, 3'b001, 32'h002, 32'h0, 32'h8001_1234, 0, '{32'hFFFF_8001, 1'b0, 32'h000, 4'b1111, 32'h0, 1'b0, 2}};
      v[4] = '{1'b0, 3'b101, 32'h002, 32'h0, 32'h8001_1234, 1, '{32'h0000_8001, 1'b0, 32'h000, 4'b1111, 32'h0, 1'b0, 3}};
      v[5] = '{1'b0, 3'b000, 32'h041, 32'h0, 32'h0000_7F00, 2, '{32'h0000_007F, 1'b0, 32'h040, 4'b1111, 32'h0, 1'b0, 4}};
      v[6] = '{1'b0, 3'b101, 32'h000, 32'h0, 32'hFFFF_8765, 0, '{32'h0000_8765, 1'b0, 32'h000, 4'b1111, 32'h0, 1'b0, 2}};
      for (int i = 0; i < 7; i++) begin
         sb.push_back(v[i].e);
         drive_access(v[i].we, v[i].f3, v[i].a, v[i].wd, v[i].rd, v[i].dly, o);
         e = sb.pop_front();
         n_checks++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL load[%0d] done: got %b expected 1 (timeout)", i, o.done); end
         n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL load[%0d] rdata: got %h expected %h", i, o.rdata, e.rdata); end
         n_checks++; if (o.fault !== e.fault) begin n_fail++; $display("FAIL load[%0d] fault: got %b expected %b", i, o.fault, e.fault); end
         n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL load[%0d] addr: got %h expected %h", i, o.addr, e.addr); end
         n_checks++; if (o.be !== e.be || o.we !== e.we) begin
            n_fail++; $display("FAIL load[%0d] be_we: got be=%b we=%b expected %b %b", i, o.be, o.we, e.be, e.we);
         end
         n_checks++; if (o.stall != e.stall) begin n_fail++; $display("FAIL load[%0d] stall: got %0d expected %0d", i, o.stall, e.stall); end
         n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL load[%0d] stable: got %b expected 1", i, o.stable); end
         @(negedge clk);
         n_checks++; if (ReadDataM !== e.rdata) begin n_fail++; $display("FAIL load[%0d] hold: got %h expected %h", i, ReadDataM, e.rdata); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_faults();
      vec_t v[5];
      obs_t o;
      exp_t e;
      v[0] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_1111, 0, '{32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1}};
      v[1] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h1111_1111, 0, '{32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1}};
      v[2] = '{1'b1, 3'b001, 32'h201, 32'h5555_5555, 32'h0, 0, '{32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1}};
      v[3] = '{1'b1, 3'b100, 32'h000, 32'h5555_5555, 32'h0, 0, '{32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1}};
      v[4] = '{1'b0, 3'b101, 32'h003, 32'h0, 32'h1111_1111, 0, '{32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1}};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(v[i].e);
         drive_access(v[i].we, v[i].f3, v[i].a, v[i].wd, v[i].rd, v[i].dly, o);
         e = sb.pop_front();
         n_checks++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL fault[%0d] done: got %b expected 1 (timeout)", i, o.done); end
         n_checks++; if (o.fault !== e.fault) begin n_fail++; $display("FAIL fault[%0d] fault: got %b expected %b", i, o.fault, e.fault); end
         n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL fault[%0d] rdata: got %h expected %h", i, o.rdata, e.rdata); end
         n_checks++; if (o.stall != e.stall) begin n_fail++; $display("FAIL fault[%0d] stall: got %0d expected %0d", i, o.stall, e.stall); end
         n_checks++; if (o.req_lat != -1) begin n_fail++; $display("FAIL fault[%0d] no_req: got req at cycle %0d expected none", i, o.req_lat); end
         @(negedge clk);
         n_checks++; if (FaultM !== 1'b0) begin n_fail++; $display("FAIL fault[%0d] pulse: got %b expected 0", i, FaultM); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2;
      exp_t e;
      sb.push_back('{32'h0, 1'b0, 32'h010, 4'b1111, 32'hCAFE_F00D, 1'b1, 2});
      sb.push_back('{32'hFFFF_F00D, 1'b0, 32'h010, 4'b1111, 32'h0, 1'b0, 2});
      drive_access(1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0, 0, o1);
      drive_access(1'b0, 3'b001, 32'h010, 32'h0, 32'h0000_F00D, 0, o2);
      e = sb.pop_front();
      n_checks++; if (o1.wdata !== e.wdata || o1.be !== e.be || o1.we !== e.we) begin
         n_fail++; $display("FAIL b2b_sw bus: got wdata=%h be=%b we=%b expected %h %b %b", o1.wdata, o1.be, o1.we, e.wdata, e.be, e.we);
      end
      n_checks++; if (o1.rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_sw rdata: got %h expected %h", o1.rdata, e.rdata); end
      e = sb.pop_front();
      n_checks++; if (o2.req_lat != 1) begin n_fail++; $display("FAIL b2b_lh req_lat: got %0d expected 1", o2.req_lat); end
      n_checks++; if (o2.addr !== e.addr || o2.we !== e.we) begin
         n_fail++; $display("FAIL b2b_lh bus: got addr=%h we=%b expected %h %b", o2.addr, o2.we, e.addr, e.we);
      end
      n_checks++; if (o2.rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_lh rdata: got %h expected %h", o2.rdata, e.rdata); end
      n_checks++; if (o2.stall != e.stall) begin n_fail++; $display("FAIL b2b_lh stall: got %0d expected %0d", o2.stall, e.stall); end
   endtask

   task automatic test_reset_mid();
      MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h040;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (dmem.DmemReq !== 1'b1) begin n_fail++; $display("FAIL rstmid busy1_req: got %b expected 1", dmem.DmemReq); end
      @(negedge clk);
      rst = 1'b1; #1;
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL rstmid stall_forced: got %b expected 0", StallM); end
      @(posedge clk); #1;
      rst = 1'b0; MemReqM = 1'b0;
      dmem.DmemAck = 1'b1; dmem.DmemRData = 32'h1111_1111;
      @(negedge clk);
      n_checks++; if (dmem.DmemReq !== 1'b0) begin n_fail++; $display("FAIL rstmid req: got %b expected 0", dmem.DmemReq); end
      n_checks++; if (ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rstmid rdata: got %h expected 0", ReadDataM); end
      n_checks++; if (FaultM !== 1'b0 || StallM !== 1'b0) begin
         n_fail++; $display("FAIL rstmid idle_out: got fault=%b stall=%b expected 0 0", FaultM, StallM);
      end
      @(posedge clk); #1;
      dmem.DmemAck = 1'b0;
      @(negedge clk);
      n_checks++; if (ReadDataM !== 32'h0 || FaultM !== 1'b0 || dmem.DmemReq !== 1'b0) begin
         n_fail++; $display("FAIL rstmid late_ack: got rdata=%h fault=%b req=%b expected 0 0 0", ReadDataM, FaultM, dmem.DmemReq);
      end
   endtask

   initial begin
      dmem.DmemAck   = 1'b0;
      dmem.DmemRData = 32'h0;
      test_reset();
      test_stores();
      test_loads();
      test_faults();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
